rat_flag_intr_unit: RTL and testbench

Holds the RAT MCU status flags (C, Z), their interrupt shadow copies, the interrupt-enable flag (I), and the external interrupt synchroniser/pending latch. It consumes the ALU's C and Z outputs under control-unit load strobes and feeds C_FLAG back as the ALU carry-in. It raises INT_REQ to the control unit's interrupt cycle. It saves and restores flags across interrupt entry (INT_ACK) and return (RETIE/RETID).

---
 rtl/rat_flag_intr_unit.sv | 90 +++++++++
 tb/tb_rat_flag_intr_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/rat_flag_intr_unit.sv
// RAT MCU flag register block: C/Z flags with interrupt shadows, the I flag,
// and the external interrupt synchroniser, edge detector and pending latch.
module rat_flag_intr_unit #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_TRIG   = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic ALU_C,
    input  logic ALU_Z,
    input  logic FLG_C_LD,
    input  logic FLG_C_SET,
    input  logic FLG_C_CLR,
    input  logic FLG_Z_LD,
    input  logic SEI,
    input  logic CLI,
    input  logic INTR,
    input  logic INT_ACK,
    input  logic RETIE,
    input  logic RETID,
    output logic C_FLAG,
    output logic Z_FLAG,
    output logic I_FLAG,
    output logic SHAD_C,
    output logic SHAD_Z,
    output logic INT_REQ
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_out;
    logic                   hist;
    logic                   pending;
    logic                   set_cond;
    logic                   ret;
    // Fills with ones after reset; edge detection waits until the chain and
    // history flop hold real samples, so a line already high at reset
    // release is not mistaken for a new edge.
    logic [SYNC_STAGES:0]   vld_pipe;

    assign sync_out = sync[SYNC_STAGES-1];
    assign ret      = RETIE | RETID;
    assign set_cond = EDGE_TRIG ? (sync_out & ~hist & vld_pipe[SYNC_STAGES])
                                : sync_out;
    assign INT_REQ  = pending & I_FLAG;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync     <= '0;
            hist     <= 1'b0;
            pending  <= 1'b0;
            vld_pipe <= '0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], INTR};
            hist     <= sync_out;
            vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
            // A new request arriving with the acknowledge survives it.
            pending  <= set_cond | (pending & ~INT_ACK);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            C_FLAG <= 1'b0;
            Z_FLAG <= 1'b0;
            SHAD_C <= 1'b0;
            SHAD_Z <= 1'b0;
        end else if (INT_ACK) begin
            SHAD_C <= C_FLAG;
            SHAD_Z <= Z_FLAG;
        end else if (ret) begin
            C_FLAG <= SHAD_C;
            Z_FLAG <= SHAD_Z;
        end else begin
            if (FLG_C_CLR)      C_FLAG <= 1'b0;
            else if (FLG_C_SET) C_FLAG <= 1'b1;
            else if (FLG_C_LD)  C_FLAG <= ALU_C;
            if (FLG_Z_LD)       Z_FLAG <= ALU_Z;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)          I_FLAG <= 1'b0;
        else if (INT_ACK) I_FLAG <= 1'b0;
        else if (RETID)   I_FLAG <= 1'b0;
        else if (RETIE)   I_FLAG <= 1'b1;
        else if (CLI)     I_FLAG <= 1'b0;
        else if (SEI)     I_FLAG <= 1'b1;
    end

endmodule

// File: tb/tb_rat_flag_intr_unit.sv
// Directed bench for rat_flag_intr_unit (SYNC_STAGES=2, EDGE_TRIG=1).
module tb_rat_flag_intr_unit;

    logic CLK = 1'b0;
    logic RST, ALU_C, ALU_Z, FLG_C_LD, FLG_C_SET, FLG_C_CLR, FLG_Z_LD;
    logic SEI, CLI, INTR, INT_ACK, RETIE, RETID;
    logic C_FLAG, Z_FLAG, I_FLAG, SHAD_C, SHAD_Z, INT_REQ;

    int checks = 0;
    int errors = 0;

    rat_flag_intr_unit #(.SYNC_STAGES(2), .EDGE_TRIG(1'b1)) dut (
        .CLK(CLK), .RST(RST), .ALU_C(ALU_C), .ALU_Z(ALU_Z),
        .FLG_C_LD(FLG_C_LD), .FLG_C_SET(FLG_C_SET), .FLG_C_CLR(FLG_C_CLR),
        .FLG_Z_LD(FLG_Z_LD), .SEI(SEI), .CLI(CLI), .INTR(INTR),
        .INT_ACK(INT_ACK), .RETIE(RETIE), .RETID(RETID),
        .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .I_FLAG(I_FLAG),
        .SHAD_C(SHAD_C), .SHAD_Z(SHAD_Z), .INT_REQ(INT_REQ)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Drop every strobe; INTR and RST are left alone.
    task automatic idle();
        ALU_C = 0; ALU_Z = 0; FLG_C_LD = 0; FLG_C_SET = 0; FLG_C_CLR = 0;
        FLG_Z_LD = 0; SEI = 0; CLI = 0; INT_ACK = 0; RETIE = 0; RETID = 0;
    endtask

    initial begin
        // Reset with every input high
        RST = 1; ALU_C = 1; ALU_Z = 1; FLG_C_LD = 1; FLG_C_SET = 1; FLG_C_CLR = 1;
        FLG_Z_LD = 1; SEI = 1; CLI = 1; INTR = 1; INT_ACK = 1; RETIE = 1; RETID = 1;
        step();
        chk("rst_c", C_FLAG, 0);
        chk("rst_z", Z_FLAG, 0);
        chk("rst_i", I_FLAG, 0);
        chk("rst_shc", SHAD_C, 0);
        chk("rst_shz", SHAD_Z, 0);
        chk("rst_req", INT_REQ, 0);
        step(2);
        chk("rst_req3", INT_REQ, 0);

        // Release reset with INTR still high: no edge may be recorded
        RST = 0; idle();
        step(6);
        SEI = 1; step(); idle();
        chk("post_rst_i", I_FLAG, 1);
        chk("post_rst_req", INT_REQ, 0);
        step(2);
        chk("post_rst_req2", INT_REQ, 0);

        // Flag loads and CLR/SET priority
        ALU_C = 1; ALU_Z = 0; FLG_C_LD = 1; FLG_Z_LD = 1; step(); idle();
        chk("ld_c", C_FLAG, 1);
        chk("ld_z", Z_FLAG, 0);
        FLG_C_SET = 1; FLG_C_CLR = 1; step(); idle();
        chk("setclr_c", C_FLAG, 0);
        FLG_C_SET = 1; step(); idle();
        chk("set_c", C_FLAG, 1);
        ALU_Z = 1; FLG_Z_LD = 1; ALU_C = 0; step(); idle();
        chk("ld_z1", Z_FLAG, 1);
        chk("hold_c", C_FLAG, 1);

        // Latency: INTR low long enough to settle, then rise before edge k
        INTR = 0; step(4);
        INTR = 1;
        step();
        chk("lat_k", INT_REQ, 0);
        step();
        chk("lat_k1", INT_REQ, 0);
        step();
        chk("lat_k2", INT_REQ, 1);
        step(8);
        chk("lat_hold", INT_REQ, 1);

        // Entry with a same-cycle CLR that must be ignored
        INT_ACK = 1; FLG_C_CLR = 1; step(); idle();
        chk("ent_shc", SHAD_C, 1);
        chk("ent_shz", SHAD_Z, 1);
        chk("ent_c", C_FLAG, 1);
        chk("ent_i", I_FLAG, 0);
        chk("ent_req", INT_REQ, 0);
        FLG_C_CLR = 1; FLG_Z_LD = 1; ALU_Z = 0; step(); idle();
        chk("isr_c", C_FLAG, 0);
        chk("isr_z", Z_FLAG, 0);
        RETIE = 1; step(); idle();
        chk("retie_c", C_FLAG, 1);
        chk("retie_z", Z_FLAG, 1);
        chk("retie_i", I_FLAG, 1);
        chk("retie_shc", SHAD_C, 1);
        // INTR is still high: a single pending set only
        chk("one_set", INT_REQ, 0);
        step(3);
        chk("one_set2", INT_REQ, 0);

        // SEI and CLI together: CLI wins
        SEI = 1; CLI = 1; step(); idle();
        chk("sei_cli", I_FLAG, 0);

        // Masked edge held pending until SEI
        INTR = 0; step(4);
        INTR = 1; step(5);
        chk("mask_req", INT_REQ, 0);
        SEI = 1; step(); idle();
        chk("unmask_i", I_FLAG, 1);
        chk("unmask_req", INT_REQ, 1);

        // RETID path
        INT_ACK = 1; step(); idle();
        chk("ent2_i", I_FLAG, 0);
        chk("ent2_req", INT_REQ, 0);
        FLG_C_CLR = 1; step(); idle();
        chk("isr2_c", C_FLAG, 0);
        RETID = 1; step(); idle();
        chk("retid_c", C_FLAG, 1);
        chk("retid_i", I_FLAG, 0);

        // Collision: edge reaches pending on the INT_ACK edge
        SEI = 1; step(); idle();
        INTR = 0; step(4);
        INTR = 1; step(2);
        INT_ACK = 1; step(); idle();
        chk("coll_req", INT_REQ, 0);
        RETIE = 1; step(); idle();
        chk("coll_i", I_FLAG, 1);
        chk("coll_req2", INT_REQ, 1);

        // Illegal combinations: INT_ACK beats RETIE, RETID beats RETIE
        INT_ACK = 1; RETIE = 1; FLG_C_CLR = 1; step(); idle();
        chk("ack_ret_i", I_FLAG, 0);
        chk("ack_ret_c", C_FLAG, 1);
        RETIE = 1; RETID = 1; step(); idle();
        chk("retie_retid_i", I_FLAG, 0);

        // Reset mid-interrupt-cycle
        RST = 1; INT_ACK = 1; RETIE = 1; step(); RST = 0; idle();
        chk("rst2_c", C_FLAG, 0);
        chk("rst2_shc", SHAD_C, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
